manual_clk_gen: RTL and testbench

//   Converts the raw single-step push button into clean manual_clk pulses for

---
 rtl/manual_clk_gen.sv | 103 ++++++++++
 tb/tb_manual_clk_gen.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/manual_clk_gen.sv
// Manual single-step clock generator.
// Synchronises and debounces the step button, then issues one fixed-width manual_clk pulse per press.
module manual_clk_gen_db #(
  parameter int DB_W     = 20,
  parameter int DB_LIMIT = 50000
) (
  input  logic raw_clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic btn_level
);
  localparam logic [DB_W-1:0] LIM_M1 = DB_W'(DB_LIMIT - 1);

  logic            s1, s2;
  logic [DB_W-1:0] cnt;

  // Any sample agreeing with the accepted level restarts the stability count.
  always_ff @(posedge raw_clk or negedge rst_n) begin
    if (!rst_n) begin
      s1        <= 1'b0;
      s2        <= 1'b0;
      cnt       <= '0;
      btn_level <= 1'b0;
    end else begin
      s1 <= btn_raw;
      s2 <= s1;
      if (s2 == btn_level) begin
        cnt <= '0;
      end else if (cnt == LIM_M1) begin
        btn_level <= s2;
        cnt       <= '0;
      end else begin
        cnt <= cnt + DB_W'(1);
      end
    end
  end
endmodule

module manual_clk_gen #(
  parameter int DB_W        = 20,
  parameter int DB_LIMIT    = 50000,
  parameter int HIGH_CYCLES = 4
) (
  input  logic        raw_clk,
  input  logic        rst_n,
  input  logic        btn_raw,
  input  logic        auto_en,
  output logic        manual_clk,
  output logic        btn_level,
  output logic [15:0] step_cnt
);
  localparam logic [7:0] HC_M1 = 8'(HIGH_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, HIGH, WAIT_REL} state_t;

  state_t     state, state_nxt;
  logic [7:0] pcnt, pcnt_nxt;
  logic       btn_level_d, rise, step_inc;

  manual_clk_gen_db #(.DB_W(DB_W), .DB_LIMIT(DB_LIMIT)) u_db (
    .raw_clk   (raw_clk),
    .rst_n     (rst_n),
    .btn_raw   (btn_raw),
    .btn_level (btn_level)
  );

  assign rise = btn_level & ~btn_level_d;

  always_comb begin
    state_nxt = state;
    pcnt_nxt  = pcnt;
    step_inc  = 1'b0;
    case (state)
      IDLE: if (rise && !auto_en) begin
        state_nxt = HIGH;
        pcnt_nxt  = '0;
        step_inc  = 1'b1;
      end
      // auto_en is not consulted here so a started pulse always completes.
      HIGH: if (pcnt == HC_M1) state_nxt = WAIT_REL;
            else               pcnt_nxt  = pcnt + 8'd1;
      WAIT_REL: if (!btn_level) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge raw_clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pcnt        <= '0;
      btn_level_d <= 1'b0;
      manual_clk  <= 1'b0;
      step_cnt    <= '0;
    end else begin
      state       <= state_nxt;
      pcnt        <= pcnt_nxt;
      btn_level_d <= btn_level;
      // Flop copy of the HIGH state keeps manual_clk glitch-free.
      manual_clk  <= (state == HIGH);
      if (step_inc) step_cnt <= step_cnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_manual_clk_gen.sv
// Randomised bench for manual_clk_gen against a window/timestamp reference model.
module tb_manual_clk_gen;
  localparam int DB = 4;
  localparam int HC = 2;

  logic        raw_clk = 1'b0;
  logic        rst_n   = 1'b0;
  logic        btn_raw = 1'b0;
  logic        auto_en = 1'b0;
  logic        manual_clk, btn_level;
  logic [15:0] step_cnt;

  manual_clk_gen #(.DB_W(20), .DB_LIMIT(DB), .HIGH_CYCLES(HC)) dut (
    .raw_clk    (raw_clk),
    .rst_n      (rst_n),
    .btn_raw    (btn_raw),
    .auto_en    (auto_en),
    .manual_clk (manual_clk),
    .btn_level  (btn_level),
    .step_cnt   (step_cnt)
  );

  always #5 raw_clk = ~raw_clk;

  int n_tests = 0;
  int n_fail  = 0;
  int mc_hi   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: raw samples delayed two edges, level flips when the last DB
  // synchronised samples all disagree with it, pulses are timestamped.
  bit          raw_q[$];
  bit          s2win[$];
  bit          m_lvl, m_lvl_d, m_busy;
  int          m_t, m_pt;
  logic [15:0] m_cnt;

  function automatic void m_reset();
    raw_q = '{1'b0, 1'b0};
    s2win.delete();
    m_lvl = 0; m_lvl_d = 0; m_busy = 0;
    m_t = 0; m_pt = -1000; m_cnt = '0;
  endfunction

  function automatic bit exp_mc();
    return (m_t > m_pt) && (m_t <= m_pt + HC);
  endfunction

  function automatic void m_edge(input bit b, input bit a);
    bit s2p, rise, flip;
    s2p = raw_q[0];
    void'(raw_q.pop_front());
    raw_q.push_back(b);
    s2win.push_back(s2p);
    if (s2win.size() > DB) void'(s2win.pop_front());
    flip = (s2win.size() == DB);
    for (int i = 0; i < s2win.size(); i++) if (s2win[i] == m_lvl) flip = 0;
    m_t++;
    rise = m_lvl && !m_lvl_d;
    if (!m_busy && rise && !a) begin
      m_busy = 1; m_pt = m_t; m_cnt = m_cnt + 16'd1;
    end else if (m_busy && m_t > m_pt + HC && !m_lvl) begin
      m_busy = 0;
    end
    m_lvl_d = m_lvl;
    if (flip) m_lvl = !m_lvl;
  endfunction

  task automatic tick();
    @(posedge raw_clk);
    if (rst_n) m_edge(btn_raw, auto_en);
    @(negedge raw_clk);
    if (rst_n) begin
      chk("manual_clk", {31'd0, manual_clk}, {31'd0, exp_mc()});
      chk("btn_level",  {31'd0, btn_level},  {31'd0, m_lvl});
      chk("step_cnt",   {16'd0, step_cnt},   {16'd0, m_cnt});
      if (manual_clk === 1'b1) mc_hi++;
    end
  endtask

  task automatic hold(input bit v, input int n);
    btn_raw = v;
    repeat (n) tick();
  endtask

  task automatic wait_pulse(input string tag);
    int k = 0;
    while (manual_clk !== 1'b1 && k < 40) begin tick(); k++; end
    chk(tag, {31'd0, manual_clk}, 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    m_reset();
    // reset with button held
    rst_n = 0; btn_raw = 1;
    repeat (3) @(negedge raw_clk);
    chk("rst_mc",  {31'd0, manual_clk}, 32'd0);
    chk("rst_lvl", {31'd0, btn_level},  32'd0);
    chk("rst_cnt", {16'd0, step_cnt},   32'd0);
    btn_raw = 0; rst_n = 1; m_reset();
    hold(0, 10);

    // clean press
    mc_hi = 0;
    hold(1, 20);
    chk("press_cnt", {16'd0, step_cnt}, 32'd1);
    chk("press_w", mc_hi, HC);
    hold(0, 20);

    // bounce that settles high, then bounce that settles low
    repeat (3) begin hold(1, 2); hold(0, 2); end
    hold(1, 20);
    chk("bounce_hi", {16'd0, step_cnt}, 32'd2);
    hold(0, 20);
    repeat (2) begin hold(1, 3); hold(0, 3); end
    hold(0, 20);
    chk("bounce_lo", {16'd0, step_cnt}, 32'd2);

    // auto mode presses, then auto_en drops while held
    auto_en = 1; mc_hi = 0;
    repeat (3) begin hold(1, 15); hold(0, 15); end
    hold(1, 15);
    auto_en = 0;
    hold(1, 15);
    hold(0, 15);
    chk("auto_cnt", {16'd0, step_cnt}, 32'd2);
    chk("auto_w", mc_hi, 0);
    hold(1, 15);
    chk("auto_next", {16'd0, step_cnt}, 32'd3);
    hold(0, 15);

    // long hold with auto_en raised in the first HIGH cycle
    mc_hi = 0; btn_raw = 1;
    begin
      int k = 0;
      while (!m_busy && k < 40) begin tick(); k++; end
    end
    auto_en = 1;
    hold(1, 100);
    chk("long_w", mc_hi, HC);
    chk("long_cnt", {16'd0, step_cnt}, 32'd4);
    auto_en = 0;
    hold(0, 20);

    // random presses, bounces and auto_en
    repeat (200) begin
      auto_en = ($urandom_range(0, 3) == 0);
      hold(1'($urandom_range(0, 1)), $urandom_range(1, 12));
    end
    auto_en = 0;
    hold(0, 20);

    // counter wrap via preload
    force dut.step_cnt = 16'hFFFF;
    #1 release dut.step_cnt;
    m_cnt = 16'hFFFF;
    hold(1, 15);
    chk("wrap", {16'd0, step_cnt}, 32'd0);
    hold(0, 15);

    // async reset in the middle of a pulse
    btn_raw = 1;
    wait_pulse("pre_rst_hi");
    #2 rst_n = 0;
    #1;
    chk("arst_mc",  {31'd0, manual_clk}, 32'd0);
    chk("arst_cnt", {16'd0, step_cnt},   32'd0);
    chk("arst_lvl", {31'd0, btn_level},  32'd0);
    btn_raw = 0;
    @(negedge raw_clk);
    rst_n = 1; m_reset();
    hold(0, 10);
    hold(1, 20);
    chk("post_rst", {16'd0, step_cnt}, 32'd1);
    hold(0, 20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
